// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Definitions shared by every elastic pipeline stage in the core.
//   - stage_state_t : occupancy state of a two-entry elastic stage
//   - CTRL field offsets : bit positions of the EX/MEM/WB control fields
//     inside the CTRL payload.  All stages (IF/ID, ID/EX, EX/MEM, MEM/WB)
//     carry the same layout so a field can be picked out anywhere in the
//     pipe with the same constant.
// ----------------------------------------------------------------------------
package pipe_pkg;

  // Number of valid entries held by the stage: none, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // EX control
  localparam int ALUSRC_BIT   = 0;
  localparam int ALUOP_LSB    = 1;
  localparam int ALUOP_W      = 2;
  localparam int REGDST_BIT   = 3;
  localparam int FUNC_LSB     = 4;
  localparam int FUNC_W       = 6;
  localparam int SHAMT_LSB    = 10;
  localparam int SHAMT_W      = 5;
  // MEM control
  localparam int MEMREAD_BIT  = 15;
  localparam int MEMWRITE_BIT = 16;
  localparam int BRANCH_BIT   = 17;
  // WB control
  localparam int REGWRITE_BIT = 18;
  localparam int MEMTOREG_BIT = 19;
  // Stop the core once this instruction retires.
  localparam int HALT_BIT     = 20;

  // Smallest CTRL width that holds every field above; bits above this are
  // spare and travel through the stage untouched.
  localparam int CTRL_W_MIN   = HALT_BIT + 1;

  // True when the control word would change architectural state if it
  // reached its stage.  A bubble must always evaluate to 0 here.
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W_MIN-1:0] c);
    return c[REGWRITE_BIT] | c[MEMWRITE_BIT] | c[MEMREAD_BIT] | c[HALT_BIT];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Free-running event counter that sticks at its all-ones value instead of
//   wrapping.  Only reset returns it to zero.
//
//   Ports
//     clk    in   1      rising-edge clock
//     reset  in   1      asynchronous, active-high reset (clears count)
//     inc    in   1      count one event this cycle
//     count  out  CNT_W  current count, straight from the register
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// ----------------------------------------------------------------------------
// pipe_stage_elastic
//   Elastic register between two core stages.  Holds up to two entries: the
//   main register M, which drives the outputs, and a skid register S, which
//   catches the entry that was already accepted in the cycle downstream
//   stopped taking data.  Because in_ready is registered, upstream only
//   learns of a stall one cycle late; S absorbs that one entry so nothing is
//   dropped or duplicated.  A flush empties the stage and presents an
//   all-zero bubble.
//
//   Ports
//     clk         in   1       rising-edge clock
//     reset       in   1       asynchronous, active-high reset; deassertion
//                              is expected to be synchronised to clk upstream
//     flush       in   1       squash every held entry (and the input) now
//     in_valid    in   1       upstream entry present
//     in_ready    out  1       stage accepts an entry this cycle (registered)
//     in_data     in   DATA_W  upstream datapath payload
//     in_ctrl     in   CTRL_W  upstream control payload
//     out_valid   out  1       entry presented downstream
//     out_ready   in   1       downstream accepts
//     out_data    out  DATA_W  head entry datapath payload (zero when empty)
//     out_ctrl    out  CTRL_W  head entry control payload (zero when empty)
//     stall_cnt   out  CNT_W   saturating count of out_valid & !out_ready
//     bubble_cnt  out  CNT_W   saturating count of !out_valid
// ----------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  stage_state_t      state_q,     state_d;
  logic [DATA_W-1:0] m_data_q,    m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,    m_ctrl_d;
  logic [DATA_W-1:0] s_data_q,    s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,    s_ctrl_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next-state and datapath selection.  Registers that stop holding a valid
  // entry are loaded with zero, so the outputs read as a harmless bubble
  // directly from the flops without any masking on the output path.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush) begin
      // Flush wins over any push or pop in the same cycle.
      state_d  = EMPTY;
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d  = ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end

        ONE: begin
          unique case ({push, pop})
            2'b10: begin
              // Downstream stalled: park the new entry behind M.
              state_d  = FULL;
              s_data_d = in_data;
              s_ctrl_d = in_ctrl;
            end
            2'b11: begin
              // Head leaves as the next one arrives: M simply reloads.
              m_data_d = in_data;
              m_ctrl_d = in_ctrl;
            end
            2'b01: begin
              state_d  = EMPTY;
              m_data_d = '0;
              m_ctrl_d = '0;
            end
            default: begin
            end
          endcase
        end

        FULL: begin
          // in_ready is low here, so the only event is a pop.
          if (pop) begin
            state_d  = ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_data_d = '0;
            s_ctrl_d = '0;
          end
        end

        default: begin
          state_d  = EMPTY;
          m_data_d = '0;
          m_ctrl_d = '0;
          s_data_d = '0;
          s_ctrl_d = '0;
        end
      endcase
    end

    // Handshake outputs are registered copies of the next occupancy.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;

  // Performance counters observe the registered handshake seen downstream.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid_q),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam int DW  = 32;
  localparam int CW  = 24;
  localparam int CNW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [CNW-1:0] stall_cnt;
  logic [CNW-1:0] bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (CNW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    logic          erdy;
    logic [CNW-1:0] estall;
  } vec_t;

  vec_t tbl[$];

  // Control word derived from the data so a stray ctrl/data pairing shows up;
  // 0xC5 in the top byte sets RegWrite among other fields.
  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return {8'hC5, d[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = ctrl_of(d);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                     input logic ev, input logic [DW-1:0] ed, input logic erdy,
                     input logic [CNW-1:0] es);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.erdy = erdy; v.estall = es;
    tbl.push_back(v);
  endtask

  logic [DW-1:0]  q[$];
  logic [CNW-1:0] stall_m;
  logic [CNW-1:0] bubble_m;

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Streaming: one entry per cycle, each visible the cycle after its push.
    for (int k = 1; k <= 8; k++) begin
      add(1'b1, 32'(k), 1'b1, 1'b0, 1'b1, 32'(k), 1'b1, 4'd0);
    end
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    // Backpressure: B lands in the skid, C waits upstream until released.
    add(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 4'd0);
    add(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 4'd1);
    add(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 4'd2);
    add(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1, 4'd2);
    add(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 4'd2);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd2);
    // Flush of a full stage while an input is offered and downstream ready.
    add(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 4'd2);
    add(1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 4'd3);
    add(1'b1, 32'h13, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 4'd3);
    add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd3);
    // Flush of a one-entry stage while a push is offered.
    add(1'b1, 32'h21, 1'b1, 1'b0, 1'b1, 32'h21, 1'b1, 4'd3);
    add(1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 4'd4);
    add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd4);

    // Reset state while reset is held.
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_stall",     64'(stall_cnt), 64'd0);
    check("rst_bubble",    64'(bubble_cnt), 64'd0);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      tick();
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      check($sformatf("v%0d_out_data", i),  64'(out_data),  64'(tbl[i].ed));
      check($sformatf("v%0d_out_ctrl", i),  64'(out_ctrl),
            tbl[i].ev ? 64'(ctrl_of(tbl[i].ed)) : 64'd0);
      check($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].erdy));
      check($sformatf("v%0d_stall", i),     64'(stall_cnt), 64'(tbl[i].estall));
    end

    // Reset asserted mid-stream with the stage full.
    drive(1'b1, 32'h31, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h32, 1'b0, 1'b0);
    tick();
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid),  64'd0);
    check("mid_rst_out_ctrl",  64'(out_ctrl),   64'd0);
    check("mid_rst_out_data",  64'(out_data),   64'd0);
    check("mid_rst_in_ready",  64'(in_ready),   64'd1);
    check("mid_rst_stall",     64'(stall_cnt),  64'd0);
    check("mid_rst_bubble",    64'(bubble_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);

    // Saturation: idle output for 20 cycles with a 4-bit counter.
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) check("post_rst_out_valid", 64'(out_valid), 64'd0);
      if (k == 5 || k >= 15) begin
        check($sformatf("bubble_sat_%0d", k), 64'(bubble_cnt), 64'(k > 15 ? 15 : k));
      end
    end
    check("sat_stall", 64'(stall_cnt), 64'd0);

    // Random traffic against a FIFO scoreboard.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    stall_m  = '0;
    bubble_m = '0;
    for (int c = 0; c < 10000; c++) begin
      logic          iv, ordy, fl, ev, erdy;
      logic [DW-1:0] d, ed;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      d    = $urandom;
      drive(iv, d, ordy, fl);

      ev   = (q.size() > 0);
      erdy = (q.size() < 2);
      ed   = ev ? q[0] : '0;
      check("rnd_out_valid", 64'(out_valid), 64'(ev));
      check("rnd_out_data",  64'(out_data),  64'(ed));
      check("rnd_out_ctrl",  64'(out_ctrl),  ev ? 64'(ctrl_of(ed)) : 64'd0);
      check("rnd_in_ready",  64'(in_ready),  64'(erdy));
      check("rnd_stall",     64'(stall_cnt), 64'(stall_m));
      check("rnd_bubble",    64'(bubble_cnt), 64'(bubble_m));

      if (ev && !ordy && stall_m != 4'hF) stall_m = stall_m + 4'd1;
      if (!ev && bubble_m != 4'hF) bubble_m = bubble_m + 4'd1;
      if (fl) begin
        q.delete();
      end else begin
        if (ev && ordy) void'(q.pop_front());
        if (iv && erdy) q.push_back(d);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
